pong_score_keeper: RTL

- Produces the two 4-bit player scores consumed by the score display, so it is the writing side of the display's score interface.
- Accepts goal events from the ball/collision logic and a player "new game" button.
- Runs the match state machine: idle, serve delay, play, game over.
- Gates ball motion through serve_enable and flags the winner.

---
 rtl/pong_score_keeper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pong_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pong_score_keeper: match FSM, score counters and serve gating.     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_goal,
  input  logic       right_goal,
  input  logic       new_game,
  output logic [3:0] rightPlayerScore,
  output logic [3:0] leftPlayerScore,
  output logic       serve_enable,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned        CNT_W      = 27;
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Reset asserts immediately but releases on clk, so no flop sees a runt release.
  logic rst_meta_q, rst_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  logic ng_meta_q, ng_sync_q, ng_prev_q, left_goal_q, right_goal_q;
  logic ng_pulse, lg_pulse, rg_pulse;

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      ng_meta_q    <= 1'b0;
      ng_sync_q    <= 1'b0;
      ng_prev_q    <= 1'b0;
      left_goal_q  <= 1'b0;
      right_goal_q <= 1'b0;
    end else begin
      ng_meta_q    <= new_game;
      ng_sync_q    <= ng_meta_q;
      ng_prev_q    <= ng_sync_q;
      left_goal_q  <= left_goal;
      right_goal_q <= right_goal;
    end
  end

  assign ng_pulse = ng_sync_q & ~ng_prev_q;
  assign lg_pulse = left_goal & ~left_goal_q;
  assign rg_pulse = right_goal & ~right_goal_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lscore_q, lscore_d, rscore_q, rscore_d;
  logic [3:0]       lscore_inc, rscore_inc;
  logic [1:0]       winner_q, winner_d;
  logic             serve_en_q, serve_en_d, game_over_q, game_over_d;

  assign lscore_inc = lscore_q + 4'd1;
  assign rscore_inc = rscore_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lscore_d = lscore_q;
    rscore_d = rscore_q;
    winner_d = winner_q;
    // A restart outranks any goal seen in the same cycle.
    if (ng_pulse) begin
      state_d  = ST_SERVE;
      cnt_d    = '0;
      lscore_d = 4'd0;
      rscore_d = 4'd0;
      winner_d = 2'b00;
    end else begin
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (lg_pulse && rg_pulse) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else if (lg_pulse) begin
            rscore_d = rscore_inc;
            cnt_d    = '0;
            if (rscore_inc == WIN) begin
              state_d  = ST_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = ST_SERVE;
            end
          end else if (rg_pulse) begin
            lscore_d = lscore_inc;
            cnt_d    = '0;
            if (lscore_inc == WIN) begin
              state_d  = ST_OVER;
              winner_d = 2'b01;
            end else begin
              state_d = ST_SERVE;
            end
          end
        end
        default: ;
      endcase
    end
    serve_en_d  = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lscore_q    <= 4'd0;
      rscore_q    <= 4'd0;
      winner_q    <= 2'b00;
      serve_en_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
      winner_q    <= winner_d;
      serve_en_q  <= serve_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign leftPlayerScore  = lscore_q;
  assign rightPlayerScore = rscore_q;
  assign winner           = winner_q;
  assign serve_enable     = serve_en_q;
  assign game_over        = game_over_q;

endmodule
`default_nettype wire
